// File: rtl/fifo.sv
// Single-clock 16x8 FIFO with registered read data and registered
// empty/full flags. Optional sticky overflow/underflow flags are compiled in
// when the FIFO_ERR_EN macro is defined.
module fifo #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  input  logic             Wen,
  input  logic             Ren,
  output logic             Fempty,
  output logic             Ffull
`ifdef FIFO_ERR_EN
  ,
  output logic             err_ovf,
  output logic             err_unf
`endif
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH:0] ONE_CNT  = (AWIDTH + 1)'(1);
  localparam logic [AWIDTH-1:0] ONE_PTR = AWIDTH'(1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AWIDTH-1:0] wptr;
  logic [AWIDTH-1:0] rptr;
  logic [AWIDTH:0]   count;
  logic [AWIDTH:0]   count_nxt;
  logic              wr_acc;
  logic              rd_acc;

  // Acceptance uses the registered flags, so the same-slot read/write case
  // (count 0 or 16) can never be accepted in both directions at once.
  always_comb begin
    wr_acc    = Wen & ~Ffull;
    rd_acc    = Ren & ~Fempty;
    count_nxt = count;
    if (wr_acc && !rd_acc)
      count_nxt = count + ONE_CNT;
    else if (rd_acc && !wr_acc)
      count_nxt = count - ONE_CNT;
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge ck) begin
    if (wr_acc)
      mem[wptr] <= Din;
  end

  // Pointers, occupancy, flags and read data register.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      Fempty <= 1'b1;
      Ffull  <= 1'b0;
      Dout   <= '0;
    end else begin
      if (wr_acc)
        wptr <= wptr + ONE_PTR;
      if (rd_acc) begin
        Dout <= mem[rptr];
        rptr <= rptr + ONE_PTR;
      end
      count  <= count_nxt;
      Fempty <= (count_nxt == '0);
      Ffull  <= (count_nxt == FULL_CNT);
    end
  end

`ifdef FIFO_ERR_EN
  // Sticky error flags: any rejected request latches until reset.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (Wen && Ffull)
        err_ovf <= 1'b1;
      if (Ren && Fempty)
        err_unf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: a reference queue is updated as stimulus is
// applied and compared against Dout/Fempty/Ffull after every clock edge.
module tb_fifo;

  logic       ck;
  logic       rst;
  logic [7:0] Din;
  logic [7:0] Dout;
  logic       Wen;
  logic       Ren;
  logic       Fempty;
  logic       Ffull;
`ifdef FIFO_ERR_EN
  logic       err_ovf;
  logic       err_unf;
`endif

  fifo #(.WIDTH(8), .AWIDTH(4)) dut (
    .ck     (ck),
    .rst    (rst),
    .Din    (Din),
    .Dout   (Dout),
    .Wen    (Wen),
    .Ren    (Ren),
    .Fempty (Fempty),
    .Ffull  (Ffull)
`ifdef FIFO_ERR_EN
    ,
    .err_ovf(err_ovf),
    .err_unf(err_unf)
`endif
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] q[$];
  logic [7:0] exp_dout = 8'h00;
  logic       exp_ovf  = 1'b0;
  logic       exp_unf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout"}, 32'(Dout), 32'(exp_dout));
    chk({tag, ".empty"}, 32'(Fempty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(Ffull), 32'(q.size() == 16));
`ifdef FIFO_ERR_EN
    chk({tag, ".ovf"}, 32'(err_ovf), 32'(exp_ovf));
    chk({tag, ".unf"}, 32'(err_unf), 32'(exp_unf));
`endif
  endtask

  // One clock: drive, update model on the edge using pre-edge state, check at +1.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input string tag);
    logic wa, ra;
    Wen = w; Ren = r; Din = d;
    @(posedge ck);
    wa = w && (q.size() < 16);
    ra = r && (q.size() > 0);
    if (w && q.size() == 16) exp_ovf = 1'b1;
    if (r && q.size() == 0)  exp_unf = 1'b1;
    if (ra) exp_dout = q.pop_front();
    if (wa) q.push_back(d);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; Wen = 1'b0; Ren = 1'b0; Din = 8'h00;
    #1;
    check_all("reset0");
    #11 rst = 1'b0;

    // Mid-stream reset with non-zero Dout beforehand.
    step(1, 0, 8'h3C, "pre_w0");
    step(1, 0, 8'h5A, "pre_w1");
    step(0, 1, 8'h00, "pre_r0");
    step(1, 0, 8'h77, "pre_w2");
    rst = 1'b1;
    #1;
    q.delete(); exp_dout = 8'h00; exp_ovf = 1'b0; exp_unf = 1'b0;
    check_all("async_rst");
    #19 rst = 1'b0;
    Wen = 1'b0; Ren = 1'b0;
    step(0, 1, 8'h00, "rd_after_rst");

    // Fill then overflow attempt.
    for (int i = 0; i < 16; i++) step(1, 0, 8'(i), "fill");
    step(1, 0, 8'hFF, "ovf");

    // Drain then underflow attempt.
    for (int i = 0; i < 16; i++) step(0, 1, 8'h00, "drain");
    step(0, 1, 8'h00, "unf");
    chk("drain_last", 32'(Dout), 32'h0F);

    // Wrap-around traffic.
    for (int i = 0; i < 10; i++) step(1, 0, 8'(8'h40 + i), "wrap_w10");
    for (int i = 0; i < 10; i++) step(0, 1, 8'h00, "wrap_r10");
    for (int i = 0; i < 12; i++) step(1, 0, 8'(8'h80 + i), "wrap_w12");
    for (int i = 0; i < 12; i++) step(0, 1, 8'h00, "wrap_r12");

    // Simultaneous read/write on empty, full and 5 entries.
    step(1, 1, 8'hA5, "both_empty");
    for (int i = 0; i < 15; i++) step(1, 0, 8'(8'hB0 + i), "refill");
    step(1, 1, 8'hEE, "both_full");
    while (q.size() > 5) step(0, 1, 8'h00, "to5");
    step(1, 1, 8'hC3, "both_5");
    chk("both_5_count", 32'(q.size()), 32'd5);
    for (int i = 0; i < 5; i++) step(0, 1, 8'h00, "drain5");

    // Random traffic.
    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), "rand");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
